pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipeline. It watches the ID, EX and MEM stages and drives the write-enable and flush controls of the PC, IF/ID, ID/EX and EX/MEM registers. It resolves load-use hazards, taken branches, jumps and multi-cycle data-memory waits under a fixed priority. It also keeps saturating stall/flush statistics and a sticky memory-timeout flag.

---
 rtl/pipeline_hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: stall/flush controller for the 5-stage pipeline (load-use, branch, jump, data-memory wait).
// Latency: control outputs are same-cycle decode; o_wait, statistics and timeout flag update at posedge.
// Backpressure: a pending data-memory access freezes the pipeline until i_mem_ready; no other input is stalled.
module pipeline_hazard_ctrl #(
  parameter int REG_W       = 6,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_uses_rs,
  input  logic             i_id_uses_rt,
  input  logic             i_id_jump,
  input  logic             i_ex_mem_read,
  input  logic [REG_W-1:0] i_ex_rt,
  input  logic             i_ex_branch_taken,
  input  logic             i_mem_req,
  input  logic             i_mem_ready,
  output logic             o_pc_write,
  output logic             o_if_id_write,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic             o_ex_mem_hold,
  output logic             o_wait,
  output logic             o_mem_timeout,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  // Wait counter saturates at MEM_TIMEOUT, so it needs enough bits to hold that value.
  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX  = WCNT_W'(MEM_TIMEOUT);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_hold;
  } ctrl_t;

  state_t            state_q;
  state_t            state_d;
  ctrl_t             ctrl;
  logic              load_use_haz;
  logic              freeze;
  logic              stall_evt;
  logic              flush_evt;
  logic [WCNT_W-1:0] wait_cnt_q;
  logic              timeout_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;

  // Hazard and freeze terms; r0 never carries a real dependency.
  always_comb begin
    load_use_haz = i_ex_mem_read && (i_ex_rt != '0) &&
                   ((i_id_uses_rs && (i_id_rs == i_ex_rt)) ||
                    (i_id_uses_rt && (i_id_rt == i_ex_rt)));
    freeze       = ((state_q == RUN) && i_mem_req && !i_mem_ready) ||
                   ((state_q == MEM_WAIT) && !i_mem_ready);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: enter MEM_WAIT on an unanswered request, leave when memory answers.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (i_mem_req && !i_mem_ready) state_d = MEM_WAIT;
      MEM_WAIT: if (i_mem_ready) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // Output decode in fixed priority: freeze, branch, load-use, jump, default.
  always_comb begin
    ctrl = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
             id_ex_flush: 1'b0, ex_mem_hold: 1'b0};
    if (freeze) begin
      // Whole pipeline holds; branch/jump/hazard are re-presented after release.
      ctrl.pc_write    = 1'b0;
      ctrl.if_id_write = 1'b0;
      ctrl.ex_mem_hold = 1'b1;
    end else if (i_ex_branch_taken) begin
      // Branch squashes both younger instructions, including any hazarding one.
      ctrl.if_id_flush = 1'b1;
      ctrl.id_ex_flush = 1'b1;
    end else if (load_use_haz) begin
      ctrl.pc_write    = 1'b0;
      ctrl.if_id_write = 1'b0;
      ctrl.id_ex_flush = 1'b1;
    end else if (i_id_jump) begin
      ctrl.if_id_flush = 1'b1;
    end
  end

  assign o_pc_write    = ctrl.pc_write;
  assign o_if_id_write = ctrl.if_id_write;
  assign o_if_id_flush = ctrl.if_id_flush;
  assign o_id_ex_flush = ctrl.id_ex_flush;
  assign o_ex_mem_hold = ctrl.ex_mem_hold;
  assign o_wait        = (state_q == MEM_WAIT);

  // Statistic events: a load-use stall only counts when a branch does not override it.
  always_comb begin
    stall_evt = freeze || (load_use_haz && !i_ex_branch_taken);
    flush_evt = !freeze && (i_ex_branch_taken || (i_id_jump && !load_use_haz));
  end

  // Saturating stall and flush counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_evt && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;

  // Wait counter: held at zero in RUN so it starts fresh on every MEM_WAIT entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else if (state_q == RUN) begin
      wait_cnt_q <= '0;
    end else if (wait_cnt_q != WCNT_MAX) begin
      wait_cnt_q <= wait_cnt_q + WCNT_W'(1);
    end
  end

  // Sticky timeout flag: sets as the counter reaches MEM_TIMEOUT; the access keeps waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_q <= 1'b0;
    end else if ((state_q == MEM_WAIT) && (wait_cnt_q == WCNT_LAST)) begin
      timeout_q <= 1'b1;
    end
  end

  assign o_mem_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Purpose: self-checking bench for pipeline_hazard_ctrl with a cycle model and directed scenarios.
// Latency: model controls are same-cycle; model statistics update at each posedge.
// Backpressure: stimulus is fixed-length; no wait depends on a DUT event.
module tb_pipeline_hazard_ctrl;

  localparam int REG_W = 6;
  localparam int CNT_W = 4;
  localparam int TO    = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [REG_W-1:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic             uses_rs = 0, uses_rt = 0, id_jump = 0, ex_mem_read = 0;
  logic             br = 0, mem_req = 0, mem_ready = 0;
  logic             pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_hold;
  logic             wait_o, timeout_o;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rs(uses_rs), .i_id_uses_rt(uses_rt),
    .i_id_jump(id_jump), .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt),
    .i_ex_branch_taken(br), .i_mem_req(mem_req), .i_mem_ready(mem_ready),
    .o_pc_write(pc_write), .o_if_id_write(if_id_write), .o_if_id_flush(if_id_flush),
    .o_id_ex_flush(id_ex_flush), .o_ex_mem_hold(ex_mem_hold), .o_wait(wait_o),
    .o_mem_timeout(timeout_o), .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic m_wait = 0;
  logic m_to   = 0;
  int   m_wcnt = 0;
  int   m_stall = 0;
  int   m_flush = 0;

  wire m_haz = ex_mem_read && (ex_rt != 0) &&
               ((uses_rs && id_rs == ex_rt) || (uses_rt && id_rt == ex_rt));
  wire m_frz = !mem_ready && (m_wait || mem_req);

  // {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_hold}
  function automatic logic [4:0] exp_ctrl(input logic frz, input logic b,
                                          input logic h, input logic j);
    if (frz)    return 5'b00001;
    else if (b) return 5'b11110;
    else if (h) return 5'b00010;
    else if (j) return 5'b11100;
    else        return 5'b11000;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_wait <= 0; m_to <= 0; m_wcnt <= 0; m_stall <= 0; m_flush <= 0;
    end else begin
      if (m_frz || (m_haz && !br))
        m_stall <= (m_stall + 1 > SAT) ? SAT : m_stall + 1;
      if (!m_frz && (br || (id_jump && !m_haz)))
        m_flush <= (m_flush + 1 > SAT) ? SAT : m_flush + 1;
      if (!m_wait) begin
        if (mem_req && !mem_ready) begin
          m_wait <= 1;
          m_wcnt <= 0;
        end
      end else begin
        m_wcnt <= m_wcnt + 1;
        if (m_wcnt + 1 >= TO) m_to <= 1;
        if (mem_ready) m_wait <= 0;
      end
    end
  end

  logic [4:0] cmp_e;
  always @(negedge clk) begin
    if (!reset) begin
      cmp_e = exp_ctrl(m_frz, br, m_haz, id_jump);
      check("pc_write",    int'(pc_write),    int'(cmp_e[4]));
      check("if_id_write", int'(if_id_write), int'(cmp_e[3]));
      check("if_id_flush", int'(if_id_flush), int'(cmp_e[2]));
      check("id_ex_flush", int'(id_ex_flush), int'(cmp_e[1]));
      check("ex_mem_hold", int'(ex_mem_hold), int'(cmp_e[0]));
      check("wait",        int'(wait_o),      int'(m_wait));
      check("timeout",     int'(timeout_o),   int'(m_to));
      check("stall_cnt",   int'(stall_cnt),   m_stall);
      check("flush_cnt",   int'(flush_cnt),   m_flush);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic clear_in();
    id_rs = '0; id_rt = '0; ex_rt = '0; uses_rs = 0; uses_rt = 0;
    id_jump = 0; ex_mem_read = 0; br = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset = 1;
    clear_in();
    tick();
    reset = 0;
  endtask

  initial begin
    clear_in();
    #1;
    // Reset state: RUN decode with idle inputs.
    check("rst_pc_write", int'(pc_write), 1);
    check("rst_if_id_write", int'(if_id_write), 1);
    check("rst_flushes", int'({if_id_flush, id_ex_flush, ex_mem_hold}), 0);
    check("rst_wait", int'(wait_o), 0);
    check("rst_cnts", int'({stall_cnt, flush_cnt, timeout_o}), 0);
    tick();
    reset = 0;
    tick();

    // Load-use: one bubble, then the load leaves EX.
    ex_mem_read = 1; ex_rt = 6'd5; id_rs = 6'd5; uses_rs = 1;
    #1;
    check("lu_pc_write", int'(pc_write), 0);
    check("lu_id_ex_flush", int'(id_ex_flush), 1);
    tick();
    ex_mem_read = 0;
    #1;
    check("lu_after_pc_write", int'(pc_write), 1);
    tick();
    check("lu_stall_cnt", int'(stall_cnt), 1);

    // Zero register and unused operand never stall.
    do_reset();
    ex_mem_read = 1; ex_rt = 6'd0; id_rs = 6'd0; uses_rs = 1;
    tick();
    ex_rt = 6'd5; id_rt = 6'd5; uses_rt = 0; id_rs = 6'd1;
    tick();
    clear_in();
    tick();
    check("nohaz_stall_cnt", int'(stall_cnt), 0);

    // Branch wins over a simultaneous load-use hazard.
    do_reset();
    ex_mem_read = 1; ex_rt = 6'd9; id_rt = 6'd9; uses_rt = 1; br = 1;
    #1;
    check("br_flushes", int'({if_id_flush, id_ex_flush, pc_write}), 7);
    tick();
    clear_in();
    tick();
    check("br_flush_cnt", int'(flush_cnt), 1);
    check("br_stall_cnt", int'(stall_cnt), 0);

    // Memory wait: ready low 3 cycles, then high with a jump pending in ID.
    do_reset();
    mem_req = 1; id_jump = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mw_hold", int'(ex_mem_hold), 1);
      check("mw_if_id_flush", int'(if_id_flush), 0);
      tick();
    end
    mem_ready = 1;
    #1;
    check("mw_release_hold", int'(ex_mem_hold), 0);
    check("mw_jump_flush", int'(if_id_flush), 1);
    check("mw_wait_last", int'(wait_o), 1);
    tick();
    clear_in();
    check("mw_wait_done", int'(wait_o), 0);
    check("mw_stall_cnt", int'(stall_cnt), 3);
    check("mw_flush_cnt", int'(flush_cnt), 1);
    // Ready in the first cycle: no freeze, no MEM_WAIT.
    mem_req = 1; mem_ready = 1;
    tick();
    clear_in();
    check("mw_fast_wait", int'(wait_o), 0);
    check("mw_fast_stall", int'(stall_cnt), 3);

    // Timeout after the 4th MEM_WAIT cycle, sticky past release.
    do_reset();
    mem_req = 1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("to_flag", int'(timeout_o), (i >= 5) ? 1 : 0);
    end
    check("to_stall_cnt", int'(stall_cnt), 10);
    mem_ready = 1;
    tick();
    clear_in();
    check("to_sticky", int'(timeout_o), 1);
    check("to_wait_clr", int'(wait_o), 0);
    // Reset mid-wait clears everything asynchronously.
    mem_req = 1;
    tick();
    tick();
    check("rmw_in_wait", int'(wait_o), 1);
    #2;
    reset = 1;
    #1;
    check("rmw_wait", int'(wait_o), 0);
    check("rmw_flag", int'(timeout_o), 0);
    check("rmw_cnts", int'({stall_cnt, flush_cnt}), 0);
    clear_in();
    tick();
    reset = 0;

    // Flush counter saturation with back-to-back jumps.
    do_reset();
    id_jump = 1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check("sat_flush_cnt", int'(flush_cnt), (i < SAT) ? i : SAT);
    end
    clear_in();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
